fifo_flex: RTL and testbench
============================

// Module: fifo_flex
// PURPOSE
//   Next-generation synchronous FIFO. Generic in width and depth. Adds a fill-level
//   output, programmable almost-full/almost-empty flags, sticky overflow/underflow
//   error flags, and a selectable read mode (registered read or first-word-fall-through).
//   It sits between single-clock producer/consumer stages as a drop-in buffer.
// PARAMETERS
//   DATA_WIDTH  8           width of wdata/rdata in bits
//   DEPTH       16          number of entries; power of two, >= 2
//   AF_LEVEL    DEPTH-2     almost_full asserts when count >= AF_LEVEL (1..DEPTH)
//   AE_LEVEL    2           almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1)
//   FWFT        0           0 = registered read, 1 = first-word-fall-through
//   (localparam PTR_W = $clog2(DEPTH))
// PORTS
//   clk           in   1            clock, rising edge
//   rst           in   1            asynchronous reset, active low
//   wenable       in   1            write request
//   wdata         in   DATA_WIDTH   write data
//   renable       in   1            read request (pop when FWFT=1)
//   rdata         out  DATA_WIDTH   read data
//   rvalid        out  1            rdata holds valid data (meaning depends on mode)
//   empty         out  1            count == 0
//   full          out  1            count == DEPTH
//   almost_empty  out  1            count <= AE_LEVEL
//   almost_full   out  1            count >= AF_LEVEL
//   count         out  PTR_W+1      current number of stored entries, 0..DEPTH
//   overflow      out  1            sticky: write was attempted while full
//   underflow     out  1            sticky: read was attempted while empty
//   clr_err       in   1            synchronous clear of overflow/underflow
// BEHAVIOUR
// - Reset (rst=0, async): wr/rd pointers=0, count=0, empty=1, full=0, almost_empty=1,
//   almost_full=0, rdata=0, rvalid=0, overflow=0, underflow=0. Memory is not reset.
//   Reset mid-operation discards all contents immediately. No output glitches to stale data.
// - Pointers are PTR_W+1 bits. The extra MSB is the wrap bit; pointers wrap modulo 2*DEPTH.
//   count = wr_ptr - rd_ptr (mod 2^(PTR_W+1)).
//   full = MSBs differ and low bits equal. empty = pointers equal.
// - All flags and count are combinational from registered pointers. They update the
//   cycle after the edge that moves a pointer.
// - Write is accepted at an edge iff wenable && !full. mem[wr_ptr]<=wdata, wr_ptr++.
// - Read is accepted at an edge iff renable && !empty. rd_ptr++.
// - Simultaneous accepted write and read: both pointers advance and count is unchanged.
// - When full, a write is rejected even if a read is accepted in the same cycle.
//   When empty, a read is rejected even if a write is accepted in the same cycle.
//   There is no bypass path.
// - FWFT=0 (registered read):
//   - On an accepted read, rdata <= mem[rd_ptr] at that edge, and rvalid=1 for the
//     following cycle only. Latency is 1 cycle from the read edge.
//   - rdata holds its value when no read is accepted.
// - FWFT=1 (first-word-fall-through):
//   - rdata = mem[rd_ptr[PTR_W-1:0]] combinationally, and rvalid = !empty.
//   - A word written at edge N is visible on rdata, with rvalid=1, in cycle N+1.
//   - renable acts as a pop/ack of the displayed word.
//   - When empty, rdata is don't-care; the bench checks it only when rvalid=1.
// - Error flags:
//   - overflow is set at an edge with wenable && full.
//   - underflow is set at an edge with renable && empty.
//   - clr_err=1 clears both flags at the edge. If a set and clr_err occur in the same
//     edge, the set wins.
//   - Rejected accesses never change pointers or memory.
// - Almost-flags follow count with no hysteresis.
//   AF_LEVEL=DEPTH makes almost_full equal to full; AE_LEVEL=0 makes almost_empty equal to empty.
// TESTING
//   T1 Reset/fill: DEPTH=16, write 0x00..0x0F on back-to-back cycles -> count steps
//      1..16; almost_full first 1 at count=14; full=1 after 16th edge.
//   T2 Overflow: while full, wenable=1 with wdata=0xAA -> count stays 16, overflow=1;
//      then drain 16 -> data 0x00..0x0F, 0xAA never appears.
//   T3 Wrap/simultaneous: with count=8 (pointers wrapped), wenable=renable=1 for 40 cycles
//      -> count stays 8; output order matches a reference queue.
//   T4 Read modes: FWFT=0: read at edge N -> rdata valid with rvalid=1 in cycle N+1.
//      FWFT=1: write 0x5C into empty FIFO -> rdata=0x5C, rvalid=1 the next cycle, with no renable.
//   T5 Underflow/clear: renable on empty -> underflow=1, rd_ptr unchanged; clr_err with a
//      simultaneous new underflow -> flag stays 1; clr_err alone -> 0.
//   T6 Async reset mid-burst: assert rst low between clock edges at count=5 -> all outputs
//      take their reset values immediately, before the next edge; the first read after
//      refill returns the first word written after reset.

Source files
------------

// File: rtl/fifo_flex.sv
// Synchronous FIFO with fill level, programmable almost flags, sticky error flags
// and a build-time choice between registered read and first-word-fall-through.
module fifo_flex #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = 2,
    parameter int FWFT       = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wenable,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic                    renable,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic                    rvalid,
    output logic                    empty,
    output logic                    full,
    output logic                    almost_empty,
    output logic                    almost_full,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow,
    output logic                    underflow,
    input  logic                    clr_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] AF_THR = (PTR_W + 1)'(AF_LEVEL);
    localparam logic [PTR_W:0] AE_THR = (PTR_W + 1)'(AE_LEVEL);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W:0]        wr_ptr;
    logic [PTR_W:0]        rd_ptr;
    logic                  wr_acc;
    logic                  rd_acc;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign count        = wr_ptr - rd_ptr;
    assign empty        = (wr_ptr == rd_ptr);
    assign full         = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                          (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign almost_full  = (count >= AF_THR);
    assign almost_empty = (count <= AE_THR);

    assign wr_acc = wenable && !full;
    assign rd_acc = renable && !empty;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: the storage array has no reset; contents are only observable through valid pointers.
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr[PTR_W-1:0]] <= wdata;
    end

    // A new error event at the same edge as clr_err keeps the flag set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wenable && full) overflow <= 1'b1;
            else if (clr_err)    overflow <= 1'b0;
            if (renable && empty) underflow <= 1'b1;
            else if (clr_err)     underflow <= 1'b0;
        end
    end

    generate
        if (FWFT == 0) begin : g_reg_read
            logic [DATA_WIDTH-1:0] rdata_q;
            logic                  rvalid_q;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    rdata_q  <= '0;
                    rvalid_q <= 1'b0;
                end else begin
                    rvalid_q <= rd_acc;
                    if (rd_acc) rdata_q <= mem[rd_ptr[PTR_W-1:0]];
                end
            end

            assign rdata  = rdata_q;
            assign rvalid = rvalid_q;
        end else begin : g_fwft_read
            // Gating with empty keeps stale memory off rdata after reset.
            assign rdata  = empty ? '0 : mem[rd_ptr[PTR_W-1:0]];
            assign rvalid = !empty;
        end
    endgenerate

endmodule

// File: tb/tb_fifo_flex.sv
// Self-checking bench for fifo_flex: registered-read, FWFT and edge-threshold
// instances share one stimulus stream and are compared against a queue model.
module tb_fifo_flex;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wenable = 1'b0;
    logic       renable = 1'b0;
    logic       clr_err = 1'b0;
    logic [7:0] wdata = 8'h00;

    logic [7:0] a_rdata, b_rdata, c_rdata;
    logic       a_rvalid, b_rvalid, c_rvalid;
    logic       a_empty, b_empty, c_empty;
    logic       a_full, b_full, c_full;
    logic       a_ae, b_ae, c_ae;
    logic       a_af, b_af, c_af;
    logic [4:0] a_count, b_count, c_count;
    logic       a_ovf, b_ovf, c_ovf;
    logic       a_unf, b_unf, c_unf;

    always #5 clk = ~clk;

    fifo_flex #(.DATA_WIDTH(8), .DEPTH(16), .FWFT(0)) u_a (
        .clk(clk), .rst(rst), .wenable(wenable), .wdata(wdata), .renable(renable),
        .rdata(a_rdata), .rvalid(a_rvalid), .empty(a_empty), .full(a_full),
        .almost_empty(a_ae), .almost_full(a_af), .count(a_count),
        .overflow(a_ovf), .underflow(a_unf), .clr_err(clr_err)
    );

    fifo_flex #(.DATA_WIDTH(8), .DEPTH(16), .FWFT(1)) u_b (
        .clk(clk), .rst(rst), .wenable(wenable), .wdata(wdata), .renable(renable),
        .rdata(b_rdata), .rvalid(b_rvalid), .empty(b_empty), .full(b_full),
        .almost_empty(b_ae), .almost_full(b_af), .count(b_count),
        .overflow(b_ovf), .underflow(b_unf), .clr_err(clr_err)
    );

    fifo_flex #(.DATA_WIDTH(8), .DEPTH(16), .AF_LEVEL(16), .AE_LEVEL(0), .FWFT(0)) u_c (
        .clk(clk), .rst(rst), .wenable(wenable), .wdata(wdata), .renable(renable),
        .rdata(c_rdata), .rvalid(c_rvalid), .empty(c_empty), .full(c_full),
        .almost_empty(c_ae), .almost_full(c_af), .count(c_count),
        .overflow(c_ovf), .underflow(c_unf), .clr_err(clr_err)
    );

    typedef struct {
        logic [7:0] wd;
        int         exp_count;
        logic       exp_af;
        logic       exp_full;
    } fill_vec_t;

    fill_vec_t  fill_tbl[16];
    int         n_cmp = 0;
    int         n_fail = 0;
    logic [7:0] mq[$];
    logic       movf = 1'b0;
    logic       munf = 1'b0;
    logic [7:0] a_hold = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_state();
        int c;
        c = mq.size();
        check("a_count", a_count, c);
        check("a_empty", a_empty, c == 0);
        check("a_full", a_full, c == 16);
        check("a_almost_empty", a_ae, c <= 2);
        check("a_almost_full", a_af, c >= 14);
        check("a_overflow", a_ovf, movf);
        check("a_underflow", a_unf, munf);
        check("b_count", b_count, c);
        check("b_full", b_full, c == 16);
        check("b_overflow", b_ovf, movf);
        check("b_underflow", b_unf, munf);
        check("c_almost_empty", c_ae, c == 0);
        check("c_almost_full", c_af, c == 16);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_a_count"}, a_count, 0);
        check({tag, "_a_empty"}, a_empty, 1);
        check({tag, "_a_full"}, a_full, 0);
        check({tag, "_a_almost_empty"}, a_ae, 1);
        check({tag, "_a_almost_full"}, a_af, 0);
        check({tag, "_a_rdata"}, a_rdata, 0);
        check({tag, "_a_rvalid"}, a_rvalid, 0);
        check({tag, "_a_overflow"}, a_ovf, 0);
        check({tag, "_a_underflow"}, a_unf, 0);
        check({tag, "_b_rvalid"}, b_rvalid, 0);
        check({tag, "_b_rdata"}, b_rdata, 0);
        check({tag, "_b_count"}, b_count, 0);
    endtask

    // One clock cycle: drive, check the FWFT head before the edge, update the model, check after.
    task automatic step(input logic w, input logic [7:0] wd, input logic r, input logic clr);
        logic wacc;
        logic racc;
        wenable = w;
        wdata   = wd;
        renable = r;
        clr_err = clr;
        #1;
        check("b_rvalid", b_rvalid, mq.size() != 0);
        if (mq.size() != 0) check("b_rdata", b_rdata, mq[0]);
        wacc = w && (mq.size() < 16);
        racc = r && (mq.size() != 0);
        if (w && mq.size() == 16) movf = 1'b1;
        else if (clr)             movf = 1'b0;
        if (r && mq.size() == 0)  munf = 1'b1;
        else if (clr)             munf = 1'b0;
        if (racc) a_hold = mq.pop_front();
        if (wacc) mq.push_back(wd);
        @(posedge clk);
        #1;
        check("a_rvalid", a_rvalid, racc);
        check("a_rdata", a_rdata, a_hold);
        check("c_rdata", c_rdata, a_hold);
        check_state();
        wenable = 1'b0;
        renable = 1'b0;
        clr_err = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected summary");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 16; i++) begin
            fill_tbl[i].wd        = 8'(i);
            fill_tbl[i].exp_count = i + 1;
            fill_tbl[i].exp_af    = (i + 1) >= 14;
            fill_tbl[i].exp_full  = (i == 15);
        end

        // Power-on reset, checked while still asserted.
        #3;
        check_reset("por");
        #9 rst = 1'b1;
        @(posedge clk);
        #1;
        check_state();

        // T1: fill back-to-back.
        for (int i = 0; i < 16; i++) begin
            step(1'b1, fill_tbl[i].wd, 1'b0, 1'b0);
            check("t1_count", a_count, fill_tbl[i].exp_count);
            check("t1_almost_full", a_af, fill_tbl[i].exp_af);
            check("t1_full", a_full, fill_tbl[i].exp_full);
        end

        // T2: overflow, then a write rejected alongside an accepted read, then drain.
        step(1'b1, 8'hAA, 1'b0, 1'b0);
        check("t2_count", a_count, 16);
        check("t2_overflow", a_ovf, 1);
        step(1'b1, 8'hAA, 1'b1, 1'b0);
        check("t2_first", a_rdata, 8'h00);
        check("t2_count_after_rw", a_count, 15);
        for (int i = 1; i < 16; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            check("t2_data", a_rdata, 8'(i));
        end
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check("t2_overflow_cleared", a_ovf, 0);

        // T3: wrapped pointers, count held at 8 under simultaneous traffic.
        for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 8'(i * 7 + 3), 1'b1, 1'b0);
            check("t3_count", a_count, 8);
        end
        for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

        // T4: FWFT shows the word without renable; registered read has one-cycle rvalid.
        step(1'b1, 8'h5C, 1'b0, 1'b0);
        check("t4_b_rvalid", b_rvalid, 1);
        check("t4_b_rdata", b_rdata, 8'h5C);
        check("t4_a_rvalid_idle", a_rvalid, 0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("t4_a_rvalid", a_rvalid, 1);
        check("t4_a_rdata", a_rdata, 8'h5C);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        check("t4_a_rvalid_drop", a_rvalid, 0);
        check("t4_a_rdata_hold", a_rdata, 8'h5C);

        // T5: underflow, clear losing to a new underflow, clear alone, no read bypass.
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("t5_underflow", a_unf, 1);
        check("t5_count", a_count, 0);
        step(1'b0, 8'h00, 1'b1, 1'b1);
        check("t5_set_wins", a_unf, 1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check("t5_cleared", a_unf, 0);
        step(1'b1, 8'h33, 1'b1, 1'b0);
        check("t5_no_bypass_count", a_count, 1);
        check("t5_no_bypass_rvalid", a_rvalid, 0);
        step(1'b0, 8'h00, 1'b1, 1'b1);
        check("t5_readback", a_rdata, 8'h33);

        // T6: asynchronous reset between edges at count 5.
        for (int i = 0; i < 6; i++) step(1'b1, 8'(8'hE0 + i), 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b1, 8'hFF, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("t6_pre_count", a_count, 5);
        #2 rst = 1'b0;
        #1;
        check_reset("t6");
        mq.delete();
        movf   = 1'b0;
        munf   = 1'b0;
        a_hold = 8'h00;
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        check_state();
        step(1'b1, 8'h71, 1'b0, 1'b0);
        step(1'b1, 8'h72, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("t6_first_after_reset", a_rdata, 8'h71);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("t6_second_after_reset", a_rdata, 8'h72);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
